// File: rtl/weight_mem_stream.sv
// weight_mem_stream
//   Loadable weight store for the CNN datapath. Words are written through a
//   load port and read either one at a time (random read) or as a
//   back-pressured burst that feeds the MAC array. If CLEAR_ON_RST is set,
//   a hardware sweep fills the whole store with zeros after reset.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_ld_en/addr/data   write strobe, address, data (addr >= DEPTH is dropped)
//   i_rd_en/addr        random-read request (accepted only in IDLE)
//   o_rd_data           random-read result, held between reads
//   o_rd_valid          1-cycle pulse: o_rd_data carries a new word
//   o_rd_err            1-cycle pulse: read rejected (busy or addr >= DEPTH)
//   i_bst_start         start a burst (sampled only in IDLE)
//   i_bst_base/len      first address, word count (0..DEPTH)
//   o_out_data/valid    stream output
//   i_out_ready         stream back-pressure
//   o_busy              high in INIT or BURST
//   o_bst_done          1-cycle pulse when a burst completes
//   o_state             current FSM state (debug)
//
// Stream handshake: a beat transfers in every cycle where o_out_valid and
// i_out_ready are both 1. Once o_out_valid rises, o_out_data and
// o_out_valid stay unchanged until the beat transfers; o_out_valid never
// depends combinationally on i_out_ready.
module weight_mem_stream #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 128,
  parameter int ADDR_W       = 7,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ld_en,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_rd_err,
  input  logic              i_bst_start,
  input  logic [ADDR_W-1:0] i_bst_base,
  input  logic [ADDR_W:0]   i_bst_len,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_bst_done,
  output logic [1:0]        o_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_rem;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  logic                r_rd_err;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_bst_done;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_ld_ok;
  logic                w_rd_ok;
  logic                w_fetch;
  logic                w_accept;
  logic                w_we;
  logic [IDX_W-1:0]    w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [ADDR_W-1:0]   w_ptr_next;

  assign w_ld_ok    = ({1'b0, i_ld_addr} < DEPTH_X);
  assign w_rd_ok    = ({1'b0, i_rd_addr} < DEPTH_X);
  assign w_accept   = r_out_valid & i_out_ready;
  // Refill the output register whenever it is empty or being drained.
  assign w_fetch    = (r_rem != '0) & (~r_out_valid | i_out_ready);
  assign w_ptr_next = (r_ptr == LAST_A) ? '0 : r_ptr + 1'b1;

  // Single write port shared by the zero-fill sweep and the load port.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (!i_rst) begin
      if (r_state == S_INIT) begin
        w_we    = 1'b1;
        w_waddr = r_cnt[IDX_W-1:0];
      end else if (i_ld_en && w_ld_ok) begin
        w_we    = 1'b1;
        w_waddr = i_ld_addr[IDX_W-1:0];
        w_wdata = i_ld_data;
      end
    end
  end

  // Reads elsewhere use the pre-edge contents, so a same-cycle write to the
  // address being read is seen only by later reads (read-first).
  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= CLEAR_ON_RST ? S_INIT : S_IDLE;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_rem       <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_err    <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_bst_done  <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_bst_done <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (i_rd_en) r_rd_err <= 1'b1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_A) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (i_bst_start) begin
            // A burst request takes priority over a same-cycle read.
            if (i_rd_en) r_rd_err <= 1'b1;
            if (i_bst_len != '0) begin
              r_ptr   <= i_bst_base;
              r_rem   <= i_bst_len;
              r_state <= S_BURST;
            end else begin
              r_bst_done <= 1'b1;
            end
          end else if (i_rd_en) begin
            if (w_rd_ok) begin
              r_rd_data  <= r_mem[i_rd_addr[IDX_W-1:0]];
              r_rd_valid <= 1'b1;
            end else begin
              r_rd_err <= 1'b1;
            end
          end
        end
        S_BURST: begin
          if (i_rd_en) r_rd_err <= 1'b1;
          if (w_fetch) begin
            r_out_data  <= r_mem[r_ptr[IDX_W-1:0]];
            r_out_valid <= 1'b1;
            r_ptr       <= w_ptr_next;
            r_rem       <= r_rem - 1'b1;
          end else if (w_accept) begin
            // No fetch while draining means every word has been issued:
            // this was the last beat.
            r_out_valid <= 1'b0;
            if (r_rem == '0) begin
              r_state    <= S_IDLE;
              r_bst_done <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_err    = r_rd_err;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_bst_done  = r_bst_done;
  assign o_busy      = (r_state != S_IDLE);
  assign o_state     = r_state;

endmodule

// File: tb/tb_weight_mem_stream.sv
module tb_weight_mem_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst1 = 1'b1;
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_addr = '0;
  logic       bst_start = 1'b0;
  logic [7:0] bst_base = '0;
  logic [8:0] bst_len = '0;
  logic       out_ready = 1'b0;

  logic [7:0] rd_data, out_data, rd_data1, out_data1;
  logic       rd_valid, rd_err, out_valid, busy, bst_done;
  logic       rd_valid1, rd_err1, out_valid1, busy1, bst_done1;
  logic [1:0] state, state1;

  int total = 0;
  int bad = 0;

  logic [7:0] got_q[$];
  logic       first_rd_err, first_rd_valid, first_busy;

  always #5 clk = ~clk;

  // ADDR_W=8 with DEPTH=128 so that out-of-range addresses are expressible.
  weight_mem_stream #(.DATA_W(8), .DEPTH(128), .ADDR_W(8), .CLEAR_ON_RST(1'b1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_rd_err(rd_err), .i_bst_start(bst_start), .i_bst_base(bst_base), .i_bst_len(bst_len),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_busy(busy), .o_bst_done(bst_done), .o_state(state)
  );

  weight_mem_stream #(.DATA_W(8), .DEPTH(128), .ADDR_W(8), .CLEAR_ON_RST(1'b0)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data1), .o_rd_valid(rd_valid1),
    .o_rd_err(rd_err1), .i_bst_start(bst_start), .i_bst_base(bst_base), .i_bst_len(bst_len),
    .o_out_data(out_data1), .o_out_valid(out_valid1), .i_out_ready(out_ready),
    .o_busy(busy1), .o_bst_done(bst_done1), .o_state(state1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick;
    ld_en = 1'b0;
  endtask

  // Starts a burst with out_ready held high and collects every beat (on dut0).
  task automatic drive_burst(input logic [7:0] base, input logic [8:0] len, input logic with_rd,
                             output int n_ticks, output logic done);
    got_q.delete();
    bst_start = 1'b1; bst_base = base; bst_len = len; out_ready = 1'b1;
    rd_en = with_rd; rd_addr = 8'd3;
    tick;
    bst_start = 1'b0; rd_en = 1'b0;
    first_rd_err = rd_err; first_rd_valid = rd_valid; first_busy = busy;
    n_ticks = 1; done = bst_done;
    while (!done && n_ticks < 40) begin
      if (out_valid) got_q.push_back(out_data);
      tick;
      n_ticks++;
      done = bst_done;
    end
  endtask

  task automatic test_reset;
    int cyc;
    rst = 1'b1; rst1 = 1'b1;
    repeat (3) tick;
    total++; if (rd_valid !== 1'b0 || rd_err !== 1'b0 || bst_done !== 1'b0) begin bad++; $display("FAIL reset_pulses got valid=%b err=%b done=%b want 000", rd_valid, rd_err, bst_done); end
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || rd_data !== 8'h00) begin bad++; $display("FAIL reset_data got ov=%b od=%h rd=%h want 0", out_valid, out_data, rd_data); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy_init got %b want 1", busy); end
    total++; if (busy1 !== 1'b0 || out_valid1 !== 1'b0) begin bad++; $display("FAIL reset_noclear got busy=%b ov=%b want 0 0", busy1, out_valid1); end
    rst = 1'b0; rst1 = 1'b0;
    cyc = 0;
    while (busy && cyc < 300) begin
      cyc++;
      if (cyc == 10) begin rd_en = 1'b1; rd_addr = 8'd5; end
      tick;
      if (cyc == 10) begin
        rd_en = 1'b0;
        total++; if (rd_err !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("FAIL init_rd_err got err=%b valid=%b want 1 0", rd_err, rd_valid); end
      end
    end
    total++; if (cyc != 128) begin bad++; $display("FAIL init_busy_cycles got %0d want 128", cyc); end
    rd_en = 1'b1; rd_addr = 8'd5;
    tick;
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h00 || rd_err !== 1'b0) begin bad++; $display("FAIL init_zero_read got v=%b d=%h e=%b want 1 00 0", rd_valid, rd_data, rd_err); end
  endtask

  task automatic test_load_read;
    do_write(8'd0, 8'h10);
    do_write(8'd1, 8'h20);
    do_write(8'd2, 8'h30);
    rd_en = 1'b1; rd_addr = 8'd1;
    tick;
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h20) begin bad++; $display("FAIL readback got v=%b d=%h want 1 20", rd_valid, rd_data); end
    tick;
    total++; if (rd_valid !== 1'b0 || rd_data !== 8'h20) begin bad++; $display("FAIL rd_pulse_hold got v=%b d=%h want 0 20", rd_valid, rd_data); end
    ld_en = 1'b1; ld_addr = 8'd2; ld_data = 8'h55; rd_en = 1'b1; rd_addr = 8'd2;
    tick;
    ld_en = 1'b0; rd_en = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h30) begin bad++; $display("FAIL read_first got v=%b d=%h want 1 30", rd_valid, rd_data); end
    rd_en = 1'b1; rd_addr = 8'd2;
    tick;
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h55) begin bad++; $display("FAIL reread got v=%b d=%h want 1 55", rd_valid, rd_data); end
  endtask

  task automatic test_burst_stall;
    int pat[6] = '{1, 0, 0, 1, 1, 1};
    int k, acc_c;
    logic done;
    for (int i = 0; i < 128; i++) do_write(8'(i), 8'(i));
    bst_start = 1'b1; bst_base = 8'd10; bst_len = 9'd4; out_ready = 1'b0;
    tick;
    bst_start = 1'b0;
    total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL stall_start got busy=%b ov=%b want 1 0", busy, out_valid); end
    k = 0; acc_c = -1; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      out_ready = (c < 6) ? pat[c][0] : 1'b1;
      if (out_valid) begin
        total++; if (out_data !== 8'(10 + k)) begin bad++; $display("FAIL stall_beat c=%0d got %0d want %0d", c, out_data, 10 + k); end
        if (out_ready) begin k++; if (k == 4) acc_c = c; end
      end
      tick;
      if (bst_done) begin
        done = 1'b1;
        total++; if (k != 4 || acc_c != c) begin bad++; $display("FAIL stall_done_timing got k=%0d c=%0d want k=4 c=%0d", k, c, acc_c); end
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stall_end got ov=%b busy=%b want 0 0", out_valid, busy); end
      end
    end
    total++; if (!done) begin bad++; $display("FAIL stall_no_done got beats=%0d want done after 4", k); end
    tick;
    total++; if (bst_done !== 1'b0) begin bad++; $display("FAIL stall_done_pulse got %b want 0", bst_done); end
  endtask

  task automatic test_wrap;
    int n;
    logic done;
    drive_burst(8'd126, 9'd4, 1'b0, n, done);
    total++; if (!done || n != 6) begin bad++; $display("FAIL wrap_timing got done=%b ticks=%0d want 1 6", done, n); end
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL wrap_count got %0d want 4", got_q.size()); end
    else if (got_q[0] !== 8'd126 || got_q[1] !== 8'd127 || got_q[2] !== 8'd0 || got_q[3] !== 8'd1) begin
      bad++; $display("FAIL wrap_data got %0d %0d %0d %0d want 126 127 0 1", got_q[0], got_q[1], got_q[2], got_q[3]);
    end
    drive_burst(8'd7, 9'd0, 1'b0, n, done);
    total++; if (!done || n != 1 || first_busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL len0 got done=%b ticks=%0d busy=%b ov=%b want 1 1 0 0", done, n, first_busy, out_valid); end
    tick;
    total++; if (bst_done !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL len0_after got done=%b ov=%b want 0 0", bst_done, out_valid); end
  endtask

  task automatic test_conflicts;
    int n;
    logic done;
    bst_start = 1'b1; bst_base = 8'd0; bst_len = 9'd3; out_ready = 1'b0;
    tick;
    bst_start = 1'b0; rd_en = 1'b1; rd_addr = 8'd5;
    tick;
    rd_en = 1'b0;
    total++; if (rd_err !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("FAIL rd_in_burst got err=%b valid=%b want 1 0", rd_err, rd_valid); end
    got_q.delete(); out_ready = 1'b1; done = 1'b0; n = 0;
    while (!done && n < 20) begin
      if (out_valid) got_q.push_back(out_data);
      tick; n++; done = bst_done;
    end
    total++; if (!done || got_q.size() != 3 || got_q[0] !== 8'd0 || got_q[2] !== 8'd2) begin bad++; $display("FAIL rd_in_burst_stream got done=%b n=%0d want 1 3 beats 0..2", done, got_q.size()); end
    drive_burst(8'd50, 9'd2, 1'b1, n, done);
    total++; if (first_rd_err !== 1'b1 || first_rd_valid !== 1'b0 || first_busy !== 1'b1) begin bad++; $display("FAIL start_and_rd got err=%b valid=%b busy=%b want 1 0 1", first_rd_err, first_rd_valid, first_busy); end
    total++; if (!done || got_q.size() != 2 || got_q[0] !== 8'd50 || got_q[1] !== 8'd51) begin bad++; $display("FAIL start_and_rd_stream got done=%b n=%0d want 1 2 beats 50 51", done, got_q.size()); end
    do_write(8'd200, 8'hEE);
    rd_en = 1'b1; rd_addr = 8'd72;
    tick;
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'd72) begin bad++; $display("FAIL ld_out_of_range got v=%b d=%h want 1 48", rd_valid, rd_data); end
    rd_en = 1'b1; rd_addr = 8'd130;
    tick;
    rd_en = 1'b0;
    total++; if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'd72) begin bad++; $display("FAIL rd_out_of_range got e=%b v=%b d=%h want 1 0 48", rd_err, rd_valid, rd_data); end
  endtask

  task automatic test_reset_mid_burst;
    int n;
    logic done;
    bst_start = 1'b1; bst_base = 8'd20; bst_len = 9'd4; out_ready = 1'b1;
    tick;
    bst_start = 1'b0;
    n = 0;
    while (!(out_valid1 && out_data1 == 8'd21) && n < 10) begin tick; n++; end
    total++; if (n >= 10) begin bad++; $display("FAIL mid_rst_2nd_beat got no beat 21 within %0d cycles want beat", n); end
    rst = 1'b1; rst1 = 1'b1;
    tick;
    total++; if (out_valid1 !== 1'b0 || busy1 !== 1'b0 || bst_done1 !== 1'b0) begin bad++; $display("FAIL mid_rst_dut1 got ov=%b busy=%b done=%b want 0 0 0", out_valid1, busy1, bst_done1); end
    total++; if (out_valid !== 1'b0 || busy !== 1'b1 || bst_done !== 1'b0) begin bad++; $display("FAIL mid_rst_dut0 got ov=%b busy=%b done=%b want 0 1 0", out_valid, busy, bst_done); end
    rst = 1'b0; rst1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (bst_done1 !== 1'b0 || out_valid1 !== 1'b0) begin bad++; $display("FAIL mid_rst_quiet i=%0d got done=%b ov=%b want 0 0", i, bst_done1, out_valid1); end
    end
    got_q.delete();
    bst_start = 1'b1; bst_base = 8'd40; bst_len = 9'd2;
    tick;
    bst_start = 1'b0;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL restart_busy got %b want 1", busy1); end
    n = 0; done = 1'b0;
    while (!done && n < 20) begin
      if (out_valid1) got_q.push_back(out_data1);
      tick; n++; done = bst_done1;
    end
    total++; if (!done || got_q.size() != 2 || got_q[0] !== 8'd40 || got_q[1] !== 8'd41) begin bad++; $display("FAIL restart_stream got done=%b n=%0d want 1 2 beats 40 41", done, got_q.size()); end
    total++; if (out_valid !== 1'b0 || bst_done !== 1'b0) begin bad++; $display("FAIL init_ignores_start got ov=%b done=%b want 0 0", out_valid, bst_done); end
  endtask

  initial begin
    test_reset;
    test_load_read;
    test_burst_stall;
    test_wrap;
    test_conflicts;
    test_reset_mid_burst;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
